// File: rtl/monitor_avalon_pkg.sv
// Shared types and constants for the debug-monitor Avalon-MM initiator.
package monitor_avalon_pkg;

   localparam int DEF_ADDR_W     = 11;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_CNT_W      = 8;
   localparam int TIMEOUT_CYCLES = 1023;
   localparam int TO_W           = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      XFER   = 2'd1,
      RDWAIT = 2'd2,
      RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/monitor_avalon_master.sv
// Avalon-MM initiator that gives the debug monitor read/write/fill access to memory.
// Optional stall timeout: define MONITOR_AVALON_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// XFER   | strobes driven, waiting for ~waitrequest
// RDWAIT | read accepted, counting down the slave read latency
// RESP   | response presented until rsp_ready
module monitor_avalon_master
   import monitor_avalon_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_address,
   input  logic [DATA_W/8-1:0] cmd_byteenable,
   input  logic [DATA_W-1:0]   cmd_writedata,
   input  logic [CNT_W-1:0]    cmd_count,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_readdata,
   output logic                rsp_last,
   output logic                rsp_error,
   output logic                busy,
   output logic [ADDR_W-1:0]   avm_address,
   output logic [DATA_W/8-1:0] avm_byteenable,
   output logic                avm_chipselect,
   output logic                avm_read,
   output logic                avm_write,
   output logic [DATA_W-1:0]   avm_writedata,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_waitrequest
);

   localparam int LAT_W = 2;
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W/8-1:0]   be_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W-1:0]     rdata_q;
   logic                  write_q;
   logic [CNT_W-1:0]      remaining_q;
   logic [LAT_W-1:0]      lat_q;
   logic                  last_q;
   logic                  err_q;
   logic                  timeout_hit;
   logic                  final_word;

   assign final_word = (remaining_q == CNT_W'(1));

`ifdef MONITOR_AVALON_MASTER_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_q;

   assign timeout_hit = (state_q == XFER) && avm_waitrequest &&
                        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Counts consecutive stalled XFER cycles; any accepted transfer or exit clears it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         to_cnt_q <= '0;
      else if ((state_q == XFER) && avm_waitrequest && !timeout_hit)
         to_cnt_q <= to_cnt_q + TO_W'(1);
      else
         to_cnt_q <= '0;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      cmd_ready      = 1'b0;
      rsp_valid      = 1'b0;
      avm_chipselect = 1'b0;
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      busy           = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_d = XFER;
         end
         XFER: begin
            avm_chipselect = 1'b1;
            avm_read       = ~write_q;
            avm_write      = write_q;
            if (!avm_waitrequest) begin
               if (!write_q)        state_d = RDWAIT;
               else if (final_word) state_d = RESP;
            end else if (timeout_hit) begin
               state_d = RESP;
            end
         end
         RDWAIT: begin
            if (lat_q == '0) state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = last_q ? IDLE : XFER;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q      <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         write_q     <= 1'b0;
         remaining_q <= '0;
         lat_q       <= '0;
         last_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (cmd_valid) begin
               addr_q      <= cmd_address;
               be_q        <= cmd_byteenable;
               wdata_q     <= cmd_writedata;
               write_q     <= cmd_write;
               remaining_q <= (cmd_count == '0) ? CNT_W'(1) : cmd_count;
               rdata_q     <= '0;
               last_q      <= 1'b0;
               err_q       <= 1'b0;
            end
            XFER: if (!avm_waitrequest) begin
               if (!write_q) begin
                  lat_q <= LAT_INIT;
               end else if (final_word) begin
                  last_q <= 1'b1;
               end else begin
                  remaining_q <= remaining_q - CNT_W'(1);
                  addr_q      <= addr_q + ADDR_W'(1);
               end
            end else if (timeout_hit) begin
               // Abandon the rest of the command and report a single errored response.
               err_q   <= 1'b1;
               last_q  <= 1'b1;
               rdata_q <= '0;
            end
            RDWAIT: begin
               if (lat_q == '0) begin
                  rdata_q <= avm_readdata;
                  last_q  <= final_word;
               end else begin
                  lat_q <= lat_q - LAT_W'(1);
               end
            end
            RESP: if (rsp_ready && !last_q) begin
               remaining_q <= remaining_q - CNT_W'(1);
               addr_q      <= addr_q + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign rsp_readdata   = rdata_q;
   assign rsp_last       = rsp_valid & last_q;
   assign rsp_error      = rsp_valid & err_q;
   assign avm_address    = addr_q;
   assign avm_byteenable = be_q;
   assign avm_writedata  = wdata_q;

endmodule
